ex_seq_ctrl: RTL and testbench
==============================

// Module: ex_seq_ctrl
// PURPOSE
//  Programmable output-pattern sequencer. Replaces a hard-coded counter/case pattern generator.
//  A small entry table is loaded over a config write port and then played out cycle by cycle
//  on the o_dv/o_data channel. Sits between the config/register interface and the downstream
//  o_dv/o_data consumer, and sequences that channel under start/stop control.
// PARAMETERS
//  DEPTH  8  number of table entries (power of 2, 2..256)
//  AW     3  table address width, = log2(DEPTH)
//  DW     8  output data width
// PORTS
//  sclk      in   1     clock, all logic on rising edge
//  rst       in   1     asynchronous active-high reset
//  cfg_we    in   1     table write strobe
//  cfg_addr  in   AW    table write address
//  cfg_data  in   DW+2  entry: [DW+1]=dv flag, [DW]=last flag, [DW-1:0]=data
//  cfg_err   out  1     1-cycle pulse: write rejected because busy
//  start     in   1     level, sampled in IDLE only
//  stop      in   1     abort request, sampled in RUN only
//  repeat_en in   1     1 = wrap to entry 0 after the last entry
//  busy      out  1     1 while state==RUN
//  done      out  1     1-cycle pulse at end of each pass
//  o_dv      out  1     output valid
//  o_data    out  DW    output data, forced 0 when o_dv=0
// BEHAVIOUR
//  Interface: one clock, sclk; reset is asynchronous and active-high, rst.
//  Reset values: table all 0; state IDLE; idx 0; busy, done, cfg_err, o_dv = 0; o_data = 0.
//  Table writes: cfg_we && !busy -> entry[cfg_addr] <= cfg_data at the edge.
//   cfg_we && busy -> no write, cfg_err=1 for the next cycle.
//  FSM states: IDLE, RUN.
//  IDLE: start=1 -> RUN, idx<=0. Outputs held at 0.
//  RUN: each edge registers entry[idx]:
//   o_dv <= dv; o_data <= dv ? data : 0.
//   First entry appears one cycle after busy rises.
//  End of pass: last flag set OR idx==DEPTH-1.
//   done=1 on the same edge that registers that entry.
//   repeat_en=1 -> idx<=0 and stay in RUN, with no idle gap.
//   repeat_en=0 -> IDLE; o_dv/o_data return to 0 on the following edge.
//  Otherwise idx <= idx+1. Unsigned AW-bit idx; it never exceeds DEPTH-1.
//  stop in RUN -> IDLE at that edge.
//   o_dv/o_data forced 0 at that edge; done not asserted; the current entry is not emitted.
//  stop and end of pass in the same cycle: stop wins (no done, no emit).
//  start held high in IDLE after a pass: a new pass begins; one IDLE cycle separates the passes.
//  start in RUN and stop in IDLE are ignored.
//  rst asserted mid-pass: immediate return to reset values, including the table contents.
//  repeat_en is sampled only at end of pass.
// STRUCTURE
//  Package ex_seq_pkg: state enum (IDLE=1'b0, RUN=1'b1) and entry field positions
//   (DV_BIT, LAST_BIT, DATA_LSB), as localparams parameterised by DW.
//  Sub-module ex_seq_table: DEPTH x (DW+2) register file.
//   One synchronous write port, one combinational read port, async reset.
//  The FSM, idx counter and output registers live in ex_seq_ctrl.
// TESTING
//  1 Reset then idle: rst high 3 cycles, then low -> all outputs 0; busy=0 for 10 cycles with start=0.
//  2 Basic pass: load e0={1,0,07}, e1={0,0,00}, e2={1,1,05}; start one cycle.
//    -> o_dv/o_data = 1/07, 0/00, 1/05; done coincides with 05; busy falls after.
//  3 Full wrap with repeat: DEPTH entries with no last flag, data=idx, all dv=1, repeat_en=1.
//    -> 0..7,0..7 back to back; done pulses on every 7.
//  4 Abort: stop asserted while e1 would be emitted.
//    -> o_dv=0 on that edge; busy=0; no done; a later start replays from e0.
//  5 Busy write plus stop/end collision: cfg_we during RUN -> cfg_err pulse, table unchanged.
//    stop on the last entry -> no done, no emit.
//  6 Mid-pass reset: rst asserted between clock edges in RUN.
//    -> outputs 0 immediately (async); a table readback pass after release gives all dv=0.

Source files
------------

// File: rtl/ex_seq_pkg.sv
// Shared types and entry-field layout for the programmable output sequencer.
package ex_seq_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Entry layout: {dv, last, data[DW-1:0]}
  localparam int DATA_LSB = 0;

  function automatic int last_pos(input int dw);
    return dw;
  endfunction

  function automatic int dv_pos(input int dw);
    return dw + 1;
  endfunction
endpackage

// File: rtl/ex_seq_table.sv
// DEPTH x EW pattern table: one synchronous write port, one combinational read port.
module ex_seq_table
  import ex_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int EW    = 10
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);
  logic [DEPTH-1:0][EW-1:0] mem;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst)     mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ex_seq_ctrl.sv
// Sequencer top: plays the loaded table out on o_dv/o_data under start/stop control.
module ex_seq_ctrl
  import ex_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW+1:0] cfg_data,
  output logic          cfg_err,
  input  logic          start,
  input  logic          stop,
  input  logic          repeat_en,
  output logic          busy,
  output logic          done,
  output logic          o_dv,
  output logic [DW-1:0] o_data
);
  localparam int DV_BIT   = dv_pos(DW);
  localparam int LAST_BIT = last_pos(DW);
  localparam logic [AW-1:0] IDX_MAX = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic [DW+1:0] entry;
  logic          dv_nxt, done_nxt;
  logic [DW-1:0] data_nxt;

  ex_seq_table #(.DEPTH(DEPTH), .AW(AW), .EW(DW + 2)) u_table (
    .sclk  (sclk),
    .rst   (rst),
    .we    (cfg_we && !busy),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx),
    .rdata (entry)
  );

  assign busy = (state == RUN);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dv_nxt    = 1'b0;
    data_nxt  = '0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          idx_nxt   = '0;
        end
      end
      RUN: begin
        // stop pre-empts both the emit and any end-of-pass done
        if (stop) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          dv_nxt   = entry[DV_BIT];
          data_nxt = entry[DV_BIT] ? entry[DATA_LSB +: DW] : '0;
          if (entry[LAST_BIT] || idx == IDX_MAX) begin
            done_nxt = 1'b1;
            idx_nxt  = '0;
            if (!repeat_en) state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      o_dv    <= 1'b0;
      o_data  <= '0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      o_dv    <= dv_nxt;
      o_data  <= data_nxt;
      done    <= done_nxt;
      cfg_err <= cfg_we && busy;
    end
  end
endmodule

// File: tb/tb_ex_seq_ctrl.sv
// Directed bench for ex_seq_ctrl with a cycle-level reference model and literal spot checks.
module tb_ex_seq_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic          sclk = 1'b0;
  logic          rst, cfg_we, start, stop, repeat_en;
  logic [AW-1:0] cfg_addr;
  logic [DW+1:0] cfg_data;
  logic          cfg_err, busy, done, o_dv;
  logic [DW-1:0] o_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit fin     = 1'b0;

  ex_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .start     (start),
    .stop      (stop),
    .repeat_en (repeat_en),
    .busy      (busy),
    .done      (done),
    .o_dv      (o_dv),
    .o_data    (o_data)
  );

  always #5 sclk = ~sclk;

  // Reference model: table contents plus "running" flag and play position.
  logic [DW+1:0] m_tab [DEPTH];
  bit            m_run  = 1'b0;
  int            m_idx  = 0;
  bit            m_dv   = 1'b0;
  logic [DW-1:0] m_data = '0;
  bit            m_done = 1'b0;
  bit            m_err  = 1'b0;
  logic [DW+1:0] m_ent;

  always @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
      m_run = 1'b0; m_idx = 0; m_dv = 1'b0; m_data = '0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_err  = cfg_we && m_run;
      m_dv   = 1'b0;
      m_data = '0;
      m_done = 1'b0;
      if (cfg_we && !m_run) m_tab[cfg_addr] = cfg_data;
      if (!m_run) begin
        if (start) begin m_run = 1'b1; m_idx = 0; end
      end else if (stop) begin
        m_run = 1'b0; m_idx = 0;
      end else begin
        m_ent  = m_tab[m_idx];
        m_dv   = m_ent[DW+1];
        m_data = m_dv ? m_ent[DW-1:0] : '0;
        if (m_ent[DW] || m_idx == DEPTH - 1) begin
          m_done = 1'b1;
          m_idx  = 0;
          if (!repeat_en) m_run = 1'b0;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end
  end

  always @(negedge sclk) begin
    if (!fin) begin
      n_tests++;
      if ({busy, o_dv, o_data, done, cfg_err} !== {m_run, m_dv, m_data, m_done, m_err}) begin
        n_fail++;
        $display("FAIL model @%0t busy/dv/data/done/err got %b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
                 $time, busy, o_dv, o_data, done, cfg_err, m_run, m_dv, m_data, m_done, m_err);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW+1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge sclk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge sclk);
    rst = 1'b0;

    // 1: reset then idle
    chk("rst_dv", o_dv, 0);
    chk("rst_data", o_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    repeat (10) begin
      @(negedge sclk);
      chk("idle_busy", busy, 0);
    end

    // 2: basic pass
    wr(0, {2'b10, 8'h07});
    wr(1, {2'b00, 8'h00});
    wr(2, {2'b11, 8'h05});
    pulse_start();
    chk("p2_busy", busy, 1);
    @(negedge sclk);
    chk("p2_e0", {o_dv, o_data, done}, {1'b1, 8'h07, 1'b0});
    @(negedge sclk);
    chk("p2_e1", {o_dv, o_data, done}, {1'b0, 8'h00, 1'b0});
    @(negedge sclk);
    chk("p2_e2", {o_dv, o_data, done}, {1'b1, 8'h05, 1'b1});
    chk("p2_busy_fall", busy, 0);
    @(negedge sclk);
    chk("p2_after", {o_dv, done}, 2'b00);

    // 3: full wrap with repeat
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), {2'b10, 8'(i)});
    repeat_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      @(negedge sclk);
      chk("p3_data", {o_dv, o_data}, {1'b1, 8'(i % DEPTH)});
      chk("p3_done", done, 32'((i % DEPTH) == DEPTH - 1));
    end
    stop = 1'b1;
    @(negedge sclk);
    stop = 1'b0;
    repeat_en = 1'b0;
    chk("p3_stop", {busy, o_dv}, 2'b00);

    // 4: abort while e1 would be emitted, then replay from e0
    wr(0, {2'b10, 8'h07});
    wr(1, {2'b00, 8'h00});
    wr(2, {2'b11, 8'h05});
    pulse_start();
    @(negedge sclk);
    chk("p4_e0", {o_dv, o_data}, {1'b1, 8'h07});
    stop = 1'b1;
    @(negedge sclk);
    stop = 1'b0;
    chk("p4_abort", {busy, o_dv, done}, 3'b000);
    @(negedge sclk);
    pulse_start();
    @(negedge sclk);
    chk("p4_replay", {o_dv, o_data}, {1'b1, 8'h07});
    repeat (3) @(negedge sclk);

    // 5: write while busy, then stop colliding with the last entry
    pulse_start();
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = {2'b11, 8'hFF};
    @(negedge sclk);
    cfg_we = 1'b0;
    chk("p5_err", cfg_err, 1);
    chk("p5_e0", o_data, 8'h07);
    @(negedge sclk);
    chk("p5_err_pulse", cfg_err, 0);
    stop = 1'b1;
    @(negedge sclk);
    stop = 1'b0;
    chk("p5_collide", {busy, o_dv, done}, 3'b000);
    @(negedge sclk);
    pulse_start();
    @(negedge sclk);
    chk("p5_tab_kept", {o_dv, o_data}, {1'b1, 8'h07});
    repeat (3) @(negedge sclk);

    // start held high: back-to-back passes with one idle cycle between
    start = 1'b1;
    repeat (10) @(negedge sclk);
    start = 1'b0;
    repeat (6) @(negedge sclk);

    // 6: asynchronous reset mid-pass, then readback of a cleared table
    pulse_start();
    @(negedge sclk);
    #2 rst = 1'b1;
    #1;
    chk("p6_async", {busy, o_dv, o_data, done}, 11'd0);
    @(negedge sclk);
    rst = 1'b0;
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge sclk);
      chk("p6_clr", {o_dv, o_data}, 9'd0);
      chk("p6_done", done, 32'(i == DEPTH - 1));
    end
    @(negedge sclk);
    chk("p6_idle", busy, 0);

    fin = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
